// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUOp and mux selects,
// FSM state encoding and the per-state control-word decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_REXEC,
        ST_RWB,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_BRANCH,
        ST_JUMP,
        ST_ADDIEX,
        ST_ANDIEX,
        ST_ORIEX,
        ST_IWB,
        ST_TRAP
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // Moore control word of a state; the fetch-time IR/PC strobes are handled in the top.
    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PCSRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            ST_REXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
            ST_ADDIEX, ST_ANDIEX, ST_ORIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = (s == ST_ANDIEX) ? ALU_AND :
                              (s == ST_ORIEX)  ? ALU_OR  : ALU_ADD;
            end
            ST_IWB: begin
                c.reg_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts consecutive cycles spent waiting for the memory handshake
// and flags expiry on the WAIT_MAX-th such cycle.
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic ready_i,
    output logic expired_o
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    assign waiting   = en_i && !ready_i;
    assign expired_o = waiting && (cnt_q == CW'(WAIT_MAX - 1));

    always_comb begin
        cnt_d = '0;
        if (waiting && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake and wait watchdog.
// Define MC_ILLEGAL_OP_EN to trap undecoded opcodes and expose illegal_op_o.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [OPCODE_W-1:0] op_code_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                branch_ne_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                mem_to_reg_o,
    output logic                reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic [1:0]          pc_src_o,
`ifdef MC_ILLEGAL_OP_EN
    output logic                illegal_op_o,
`endif
    output logic                mem_err_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   br_ne_q, br_ne_d;
    logic   mem_err_q, mem_err_d;
    logic   wait_en, wait_expired, fetch_strobe;

    assign wait_en = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (wait_en),
        .ready_i   (mem_ready_i),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!mem_err_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (wait_expired) begin
                    state_d   = ST_IDLE;
                    mem_err_d = 1'b1;
                end else if (mem_ready_i) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if      (op_code_i == OPCODE_W'(OP_RTYPE)) state_d = ST_REXEC;
                else if (op_code_i == OPCODE_W'(OP_LW))    state_d = ST_MEMADR;
                else if (op_code_i == OPCODE_W'(OP_SW))    state_d = ST_MEMADR;
                else if (op_code_i == OPCODE_W'(OP_BEQ))   state_d = ST_BRANCH;
                else if (op_code_i == OPCODE_W'(OP_BNE))   state_d = ST_BRANCH;
                else if (op_code_i == OPCODE_W'(OP_J))     state_d = ST_JUMP;
                else if (op_code_i == OPCODE_W'(OP_ADDI))  state_d = ST_ADDIEX;
                else if (op_code_i == OPCODE_W'(OP_ANDI))  state_d = ST_ANDIEX;
                else if (op_code_i == OPCODE_W'(OP_ORI))   state_d = ST_ORIEX;
`ifdef MC_ILLEGAL_OP_EN
                else                                       state_d = ST_TRAP;
`else
                else                                       state_d = ST_FETCH;
`endif
            end
            ST_REXEC:  state_d = ST_RWB;
            ST_MEMADR: state_d = (op_code_i == OPCODE_W'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (wait_expired) begin
                    state_d   = ST_IDLE;
                    mem_err_d = 1'b1;
                end else if (mem_ready_i) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWR: begin
                if (wait_expired) begin
                    state_d   = ST_IDLE;
                    mem_err_d = 1'b1;
                end else if (mem_ready_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ADDIEX, ST_ANDIEX, ST_ORIEX: state_d = ST_IWB;
            ST_RWB, ST_MEMWB, ST_BRANCH, ST_JUMP, ST_IWB: state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d  = state_ctrl(state_d);
        br_ne_d = (state_d == ST_BRANCH) && op_code_i[0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            br_ne_q   <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            br_ne_q   <= br_ne_d;
            mem_err_q <= mem_err_d;
        end
    end

    // IR and PC must latch the word memory presents in the handshake cycle itself,
    // so these two strobes qualify the registered FETCH state with mem_ready_i.
    assign fetch_strobe = (state_q == ST_FETCH) && mem_ready_i;

    assign pc_write_o      = ctrl_q.pc_write | fetch_strobe;
    assign ir_write_o      = fetch_strobe;
    assign pc_write_cond_o = ctrl_q.pc_write_cond;
    assign branch_ne_o     = br_ne_q;
    assign iord_o          = ctrl_q.iord;
    assign mem_read_o      = ctrl_q.mem_read;
    assign mem_write_o     = ctrl_q.mem_write;
    assign mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign reg_dst_o       = ctrl_q.reg_dst;
    assign reg_write_o     = ctrl_q.reg_write;
    assign alu_src_a_o     = ctrl_q.alu_src_a;
    assign alu_src_b_o     = ctrl_q.alu_src_b;
    assign alu_op_o        = ALUOP_W'(ctrl_q.alu_op);
    assign pc_src_o        = ctrl_q.pc_src;
    assign mem_err_o       = mem_err_q;

`ifdef MC_ILLEGAL_OP_EN
    logic illegal_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state_d == ST_TRAP);
        end
    end

    assign illegal_op_o = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle model vs DUT outputs.
module tb_multicycle_control;
    import mips_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       mem_err;
        logic       illegal_op;
    } exp_t;

    typedef struct {
        logic       ready;
        logic [5:0] op;
        exp_t       e;
        int         idx;
    } step_t;

    logic clk, rst_n, mem_ready;
    logic [5:0] op_code;
    logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a, mem_err, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;

    multicycle_control dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .op_code_i       (op_code),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .branch_ne_o     (branch_ne),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .pc_src_o        (pc_src),
`ifdef MC_ILLEGAL_OP_EN
        .illegal_op_o    (illegal_op),
`endif
        .mem_err_o       (mem_err)
    );

`ifndef MC_ILLEGAL_OP_EN
    assign illegal_op = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t act;
    always_comb begin
        act = '0;
        act.pc_write      = pc_write;
        act.pc_write_cond = pc_write_cond;
        act.branch_ne     = branch_ne;
        act.iord          = iord;
        act.mem_read      = mem_read;
        act.mem_write     = mem_write;
        act.ir_write      = ir_write;
        act.mem_to_reg    = mem_to_reg;
        act.reg_dst       = reg_dst;
        act.reg_write     = reg_write;
        act.alu_src_a     = alu_src_a;
        act.alu_src_b     = alu_src_b;
        act.alu_op        = alu_op;
        act.pc_src        = pc_src;
        act.mem_err       = mem_err;
        act.illegal_op    = illegal_op;
    end

    step_t sq[$];
    int n_chk = 0;
    int n_pass = 0;
    int cur_idx = 0;
    int rw_idx = 0;
    int mtr_cnt = 0;

    task automatic check_int(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic push(input logic r, input logic [5:0] op, input exp_t e);
        step_t s;
        cur_idx++;
        s.ready = r;
        s.op    = op;
        s.e     = e;
        s.idx   = cur_idx;
        sq.push_back(s);
    endtask

    task automatic push_idle(input logic err);
        exp_t e;
        e = '0;
        e.mem_err = err;
        cur_idx = 0;
        push(1'b1, 6'b0, e);
    endtask

    // One instruction as seen from the outside: fetch with fw stall cycles, decode,
    // then the opcode's execute/memory/writeback phases (mw stall cycles on memory).
    task automatic add_instr(input logic [5:0] op, input int fw, input int mw, output int len);
        exp_t e;
        cur_idx = 0;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
            push(1'b0, op, e);
        end
        e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1;
        push(1'b1, op, e);
        e = '0; e.alu_src_b = 2'b11;
        push(1'b1, op, e);
        case (op)
            6'b000000: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 3'b010;
                push(1'b1, op, e);
                e = '0; e.reg_dst = 1; e.reg_write = 1;
                push(1'b1, op, e);
            end
            6'b100011, 6'b101011: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
                push(1'b1, op, e);
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.iord = 1;
                    if (op == 6'b100011) e.mem_read = 1; else e.mem_write = 1;
                    push(i == mw, op, e);
                end
                if (op == 6'b100011) begin
                    e = '0; e.mem_to_reg = 1; e.reg_write = 1;
                    push(1'b1, op, e);
                end
            end
            6'b000100, 6'b000101: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_write_cond = 1;
                e.pc_src = 2'b01; e.branch_ne = op[0];
                push(1'b1, op, e);
            end
            6'b000010: begin
                e = '0; e.pc_write = 1; e.pc_src = 2'b10;
                push(1'b1, op, e);
            end
            6'b001000, 6'b001100, 6'b001101: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
                e.alu_op = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 : 3'b000;
                push(1'b1, op, e);
                e = '0; e.reg_write = 1;
                push(1'b1, op, e);
            end
            default: begin
`ifdef MC_ILLEGAL_OP_EN
                for (int i = 0; i < 3; i++) begin
                    e = '0; e.illegal_op = 1;
                    push(1'b1, op, e);
                end
`endif
            end
        endcase
        len = cur_idx;
    endtask

    // Called at posedge+1; drives each cycle's inputs, compares at negedge.
    task automatic run();
        step_t s;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            mem_ready = s.ready;
            op_code   = s.op;
            @(negedge clk);
            n_chk++;
            if (act === s.e) n_pass++;
            else $display("FAIL cycle op=%b idx=%0d: got %h expected %h", s.op, s.idx, act, s.e);
            if (act.reg_write) rw_idx = s.idx;
            if (act.mem_to_reg) mtr_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_int("reset_outputs_zero", int'(act), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        rst_n = 1'b0; mem_ready = 1'b1; op_code = 6'b0;
        @(posedge clk); #1;
        reset_dut();

        push_idle(1'b0);
        add_instr(OP_RTYPE, 0, 0, len);
        check_int("len_rtype", len, 4);
        rw_idx = 0;
        run();
        check_int("rtype_regwrite_cycle", rw_idx, 4);

        add_instr(OP_LW, 0, 0, len);   check_int("len_lw", len, 5);
        add_instr(OP_SW, 0, 0, len);   check_int("len_sw", len, 4);
        add_instr(OP_BEQ, 0, 0, len);  check_int("len_beq", len, 3);
        add_instr(OP_BNE, 0, 0, len);  check_int("len_bne", len, 3);
        add_instr(OP_J, 0, 0, len);    check_int("len_j", len, 3);
        add_instr(OP_ADDI, 0, 0, len); check_int("len_addi", len, 4);
        add_instr(OP_ANDI, 0, 0, len);
        add_instr(OP_ORI, 0, 0, len);
        run();

        add_instr(OP_LW, 0, 3, len);
        check_int("len_lw_wait3", len, 8);
        rw_idx = 0; mtr_cnt = 0;
        run();
        check_int("lw_wait3_regwrite_cycle", rw_idx, 8);
        check_int("lw_wait3_memtoreg_pulses", mtr_cnt, 1);

        add_instr(OP_SW, 0, 14, len);
        add_instr(OP_RTYPE, 2, 0, len);
        add_instr(OP_ORI, 14, 0, len);
        run();

        add_instr(6'b111111, 0, 0, len);
`ifndef MC_ILLEGAL_OP_EN
        check_int("len_nop", len, 2);
        add_instr(OP_ADDI, 0, 0, len);
`endif
        run();
`ifdef MC_ILLEGAL_OP_EN
        reset_dut();
        push_idle(1'b0);
`endif

        add_instr(OP_SW, 0, 20, len);
        while (sq.size() > 5) void'(sq.pop_back());
        run();
        rst_n = 1'b0;
        #1;
        check_int("midop_reset_memwrite", int'(mem_write), 0);
        check_int("midop_reset_all_zero", int'(act), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_idle(1'b0);
        add_instr(OP_RTYPE, 0, 0, len);
        run();

        begin
            exp_t e;
            cur_idx = 0;
            for (int i = 0; i < 15; i++) begin
                e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
                push(1'b0, OP_RTYPE, e);
            end
            for (int i = 0; i < 5; i++) push_idle(1'b1);
        end
        run();
        check_int("watchdog_memerr_sticky", int'(mem_err), 1);

        reset_dut();
        push_idle(1'b0);
        add_instr(OP_J, 0, 0, len);
        run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
